// File: rtl/scrolling_map_if.sv
// scrolling_map_if: scroll strobe, insert selects and flat map outputs of the lane map generator
interface scrolling_map_if #(parameter int ROWS = 16, parameter int LANES = 4);
    logic                    move_map;
    logic                    sel_obstacle;
    logic                    sel_objective;
    logic [ROWS*LANES-1:0]   map_obstacles_flat;
    logic [ROWS*LANES-1:0]   map_objectives_flat;
    logic                    obstacle_generated;
    logic                    objective_generated;
    modport master(
        output move_map, sel_obstacle, sel_objective,
        input  map_obstacles_flat, map_objectives_flat, obstacle_generated, objective_generated
    );
    modport slave(
        input  move_map, sel_obstacle, sel_objective,
        output map_obstacles_flat, map_objectives_flat, obstacle_generated, objective_generated
    );
endinterface

// File: rtl/scrolling_map_generator.sv
// scrolling_map_generator: scrolls obstacle/objective lane maps toward the player, new top row lane picked by an LFSR
module scrolling_map_generator #(
    parameter int          ROWS      = 16,
    parameter int          LANES     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic             clock,
    input logic             reset,
    scrolling_map_if.slave  bus
);
    logic [15:0]           lfsr;
    logic [ROWS*LANES-1:0] obs_q, obj_q;
    logic                  obs_pulse, obj_pulse;
    logic [1:0]            obs_lane, obj_lane, rem;
    logic [LANES-1:0]      new_obs, new_obj;
    logic                  fb;
    always_comb begin
        fb       = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        rem      = lfsr[3:2] == 2'd3 ? 2'd0 : lfsr[3:2];
        obs_lane = lfsr[1:0];
        // offset of 1..3 from the obstacle lane keeps both inserts in distinct lanes
        obj_lane = bus.sel_obstacle ? obs_lane + 2'd1 + rem : lfsr[3:2];
        new_obs  = bus.sel_obstacle ? LANES'(1) << obs_lane : '0;
        new_obj  = bus.sel_objective ? LANES'(1) << obj_lane : '0;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr      <= LFSR_SEED;
            obs_q     <= '0;
            obj_q     <= '0;
            obs_pulse <= 1'b0;
            obj_pulse <= 1'b0;
        end else begin
            lfsr      <= {fb, lfsr[15:1]};
            obs_pulse <= bus.move_map & bus.sel_obstacle;
            obj_pulse <= bus.move_map & bus.sel_objective;
            if (bus.move_map) begin
                obs_q <= {new_obs, obs_q[ROWS*LANES-1:LANES]};
                obj_q <= {new_obj, obj_q[ROWS*LANES-1:LANES]};
            end
        end
    end
    assign bus.map_obstacles_flat  = obs_q;
    assign bus.map_objectives_flat = obj_q;
    assign bus.obstacle_generated  = obs_pulse;
    assign bus.objective_generated = obj_pulse;
endmodule

// File: tb/tb_scrolling_map_generator.sv
// tb_scrolling_map_generator: directed scenarios plus a long randomised run against a row-array model
module tb_scrolling_map_generator;
    localparam int ROWS  = 16;
    localparam int LANES = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    scrolling_map_if #(.ROWS(ROWS), .LANES(LANES)) bus ();
    scrolling_map_generator #(.ROWS(ROWS), .LANES(LANES), .LFSR_SEED(16'hACE1)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clock = ~clock;

    task automatic drive(input logic mv, input logic so, input logic sj);
        bus.move_map      = mv;
        bus.sel_obstacle  = so;
        bus.sel_objective = sj;
    endtask

    task automatic check_state(input string name, input logic [63:0] eobs, input logic [63:0] eobj,
                               input logic ep_obs, input logic ep_obj);
        checks++;
        if (bus.map_obstacles_flat !== eobs) begin
            errors++;
            $display("FAIL %s obstacles: got %h expected %h", name, bus.map_obstacles_flat, eobs);
        end
        checks++;
        if (bus.map_objectives_flat !== eobj) begin
            errors++;
            $display("FAIL %s objectives: got %h expected %h", name, bus.map_objectives_flat, eobj);
        end
        checks++;
        if ({bus.obstacle_generated, bus.objective_generated} !== {ep_obs, ep_obj}) begin
            errors++;
            $display("FAIL %s pulses: got %b%b expected %b%b", name, bus.obstacle_generated,
                     bus.objective_generated, ep_obs, ep_obj);
        end
    endtask

    task automatic restart(input logic so, input logic sj);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, so, sj);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_state("reset", 64'h0, 64'h0, 1'b0, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        check_state("reset_hold", 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_first_insert;
        restart(1'b1, 1'b1);
        check_state("first_insert", 64'h2000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b1);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        check_state("first_insert_hold", 64'h2000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_objective_only;
        restart(1'b0, 1'b1);
        check_state("objective_only", 64'h0, 64'h1000_0000_0000_0000, 1'b0, 1'b1);
    endtask

    task automatic test_scroll_through;
        restart(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 1'b0);
            @(posedge clock);
            #1;
        end
        check_state("scroll_row0", 64'h2, 64'h4, 1'b0, 1'b0);
        @(negedge clock);
        @(posedge clock);
        #1;
        check_state("scroll_out", 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        restart(1'b1, 1'b1);
        check_state("b2b_first", 64'h2000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        check_state("b2b_second", 64'h1200_0000_0000_0000, 64'h2400_0000_0000_0000, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_scroll;
        restart(1'b1, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_state("mid_reset_now", 64'h0, 64'h0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_state("mid_reset_edge", 64'h0, 64'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        check_state("mid_reset_replay", 64'h2000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b1);
    endtask

    task automatic test_random;
        logic [15:0] l;
        logic [3:0]  mobs[ROWS];
        logic [3:0]  mobj[ROWS];
        logic [63:0] eobs, eobj;
        logic [3:0]  r;
        logic        mv, so, sj, pobs, pobj;
        int          ol, jl, scrolls;
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        l = 16'hACE1;
        for (int k = 0; k < ROWS; k++) begin
            mobs[k] = 4'h0;
            mobj[k] = 4'h0;
        end
        scrolls = 0;
        while (scrolls < 10000) begin
            mv = ($urandom_range(0, 2) != 0);
            so = $urandom_range(0, 1) == 1;
            sj = $urandom_range(0, 1) == 1;
            drive(mv, so, sj);
            pobs = mv & so;
            pobj = mv & sj;
            if (mv) begin
                scrolls++;
                ol = int'(l[1:0]);
                jl = so ? (ol + 1 + int'(l[3:2]) % 3) % 4 : int'(l[3:2]);
                for (int k = 0; k < ROWS - 1; k++) begin
                    mobs[k] = mobs[k+1];
                    mobj[k] = mobj[k+1];
                end
                mobs[ROWS-1] = so ? 4'b0001 << ol : 4'h0;
                mobj[ROWS-1] = sj ? 4'b0001 << jl : 4'h0;
            end
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
            for (int k = 0; k < ROWS; k++) begin
                eobs[k*4 +: 4] = mobs[k];
                eobj[k*4 +: 4] = mobj[k];
            end
            @(posedge clock);
            #1;
            check_state("random", eobs, eobj, pobs, pobj);
            for (int k = 0; k < ROWS; k++) begin
                r = bus.map_obstacles_flat[k*4 +: 4];
                checks++;
                if ((r & (r - 4'd1)) != 4'h0) begin
                    errors++;
                    $display("FAIL onehot_obs row %0d: got %b expected zero or one-hot", k, r);
                end
                r = bus.map_objectives_flat[k*4 +: 4];
                checks++;
                if ((r & (r - 4'd1)) != 4'h0) begin
                    errors++;
                    $display("FAIL onehot_obj row %0d: got %b expected zero or one-hot", k, r);
                end
            end
            checks++;
            if ((bus.map_obstacles_flat[63:60] & bus.map_objectives_flat[63:60]) != 4'h0) begin
                errors++;
                $display("FAIL lane_clash: got %b/%b expected disjoint", bus.map_obstacles_flat[63:60],
                         bus.map_objectives_flat[63:60]);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        test_reset();
        test_first_insert();
        test_objective_only();
        test_scroll_through();
        test_back_to_back();
        test_reset_mid_scroll();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scrolling_map_generator.md
Name: scrolling_map_generator

Overview:
- Generates and scrolls the lane map for the delivery game.
- Holds ROWS rows of LANES-bit lane masks for obstacles and a parallel array for objectives.
- Row 0 is the row at the player; row ROWS-1 is the newest, farthest row.
- On each move_map pulse the map shifts one row toward the player, and a new top row is inserted; its lane is chosen by an internal LFSR.
- Sits between the scroll-rate/placement counters (which drive move_map, sel_obstacle, sel_objective) and the collision/display logic (which reads the flat map buses).

Parameters:
- ROWS, 16, number of map rows.
- LANES, 4, lanes per row. Lane masks are one-hot or zero; the lane-selection arithmetic requires LANES=4.
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset. Must be nonzero.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- move_map  in  1  single-cycle scroll strobe.
- sel_obstacle  in  1  insert an obstacle in the new row (sampled only when move_map=1).
- sel_objective  in  1  insert an objective in the new row (sampled only when move_map=1).
- map_obstacles_flat  out  ROWS*LANES  row k occupies bits [k*LANES +: LANES].
- map_objectives_flat  out  ROWS*LANES  same packing as map_obstacles_flat.
- obstacle_generated  out  1  one-cycle pulse: a nonzero obstacle row was inserted.
- objective_generated  out  1  one-cycle pulse: a nonzero objective row was inserted.

Behaviour:
- Reset (asynchronous, dominates everything):
  - All rows of both maps = 0.
  - Both pulse outputs = 0.
  - lfsr = LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, advances on every clock edge while not in reset, regardless of other inputs.
  - Update: fb = l[0]^l[2]^l[3]^l[5]; l_next = {fb, l[15:1]}.
  - From ACE1 the sequence is ACE1 → 5670 → ...
  - Lane selection on an edge uses the pre-edge (registered) lfsr value.
- Lane choice on an edge where move_map=1:
  - obs_lane = lfsr[1:0].
  - If sel_obstacle and sel_objective are both 1: obj_lane = (obs_lane + 1 + (lfsr[3:2] mod 3)) mod 4. This never equals obs_lane.
  - If only sel_objective is 1: obj_lane = lfsr[3:2].
  - New obstacle row = sel_obstacle ? (1<<obs_lane) : 0.
  - New objective row = sel_objective ? (1<<obj_lane) : 0.
- Scroll (edge with move_map=1):
  - row[k] <= row[k+1] for k = 0..ROWS-2, in both maps.
  - row[ROWS-1] <= the new row.
  - Old row 0 is discarded.
  - New rows are visible on the flat outputs the cycle after the edge; no other latency.
- Edge with move_map=0:
  - Both maps hold.
  - sel_obstacle and sel_objective are ignored.
  - Both pulses are 0.
- Pulses:
  - Registered.
  - obstacle_generated = 1 for exactly the one cycle following an inserting edge with move_map=1 and sel_obstacle=1; likewise objective_generated for sel_objective.
  - Back-to-back move_map cycles produce back-to-back pulses.
- Invariants:
  - Every row in each map is zero or one-hot.
  - In the newly inserted row, obstacle and objective never share a lane.
  - Rows are only ever shifted, never modified.
- Reset mid-scroll: maps clear immediately; an in-flight pulse is dropped.

Test Plan:
- Reset → both flat buses = 64'h0, both pulses 0. Hold move_map=0 with sel_obstacle=1 for 10 cycles → still all zero, pulses 0.
- Release reset; on the first edge assert move_map=1, sel_obstacle=1, sel_objective=1 (lfsr=ACE1) → obstacles[63:60]=4'b0010, objectives[63:60]=4'b0100, both pulses =1 for one cycle.
- As the previous scenario but with sel_obstacle=0 only → obstacles[63:60]=4'b0000, objectives[63:60]=4'b0001, only objective_generated pulses.
- Insert a row, then apply 15 further move_map pulses with sel=0 → the inserted mask reaches bits [3:0]. One more pulse → the map is all zero.
- Random long run (≥10k scrolls, random sel_* and gaps) against a reference model → every row is zero or one-hot, no inserted lane clash, maps and pulses match the model exactly.
- Assert reset while the map is populated and move_map=1 → immediate clear, no pulse. After release the LFSR restarts at ACE1, so the first-insert scenario repeats identically.
